// File: rtl/seg7_decimal_display.sv
// Binary-to-decimal seven-segment driver: sequential double-dabble conversion, one shift per clock.
// Optional LEADING_ZERO_BLANK_EN blanks zero digits above the most significant nonzero digit.
module seg7_decimal_display #(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      value,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [WIDTH-1:0]    bin;
  logic [BCD_W-1:0]    bcd;
  logic [BCD_W-1:0]    bcd_adj;
  logic [CNT_W-1:0]    cnt;
  logic                ovf_sticky;
  logic [7*DIGITS-1:0] hex_next;
`ifdef LEADING_ZERO_BLANK_EN
  logic                seen;
`endif

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: assign a default first in every always_comb so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == CNT_W'(WIDTH - 1)) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Digit decode from the final BCD value; scanned from the top digit so blanking stops at the first nonzero.
  always_comb begin
    hex_next = '1;
`ifdef LEADING_ZERO_BLANK_EN
    seen = 1'b0;
`endif
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (ovf_sticky) begin
        hex_next[7*i +: 7] = 7'b0111111;
      end else begin
`ifdef LEADING_ZERO_BLANK_EN
        if (bcd[4*i +: 4] != 4'd0 || i == 0) seen = 1'b1;
        hex_next[7*i +: 7] = seen ? seg(bcd[4*i +: 4]) : 7'b1111111;
`else
        hex_next[7*i +: 7] = seg(bcd[4*i +: 4]);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin        <= '0;
      bcd        <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      hex        <= '1;
      overflow   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= (state == LOAD);
      case (state)
        IDLE: begin
          if (start) begin
            bin        <= value;
            bcd        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
          end
        end
        SHIFT: begin
          // A one leaving the top digit means the value needs more digits than are available.
          {bcd, bin} <= {bcd_adj[BCD_W-2:0], bin, 1'b0};
          ovf_sticky <= ovf_sticky | bcd_adj[BCD_W-1];
          cnt        <= cnt + CNT_W'(1);
        end
        LOAD: begin
          hex      <= hex_next;
          overflow <= ovf_sticky;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seg7_decimal_display.md
Name: seg7_decimal_display

Overview:
Parametrised successor to the two-digit position display driver. It converts an unsigned binary value of WIDTH bits into DIGITS decimal digits, using a sequential shift-add-3 (double-dabble) converter with one shift per clock. It drives DIGITS active-low seven-segment outputs through a start/busy/done handshake. It sits between game-state logic (score, position, lives) and the board HEX displays, and holds the last result until the next conversion completes.

Parameters:
WIDTH, 6, bit width of the binary input value (1..32)
DIGITS, 2, number of decimal digits / seven-segment displays driven (1..8)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
value  input  WIDTH  unsigned binary value to display; captured on accepted start
start  input  1  conversion request; accepted only when busy=0
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when new display data is valid
overflow  output  1  high when the last converted value is >= 10^DIGITS
hex  output  7*DIGITS  segments, active-low, order gfedcba; digit i at bits [7i+6:7i], digit 0 = least significant

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; busy=0, done=0, overflow=0; every hex digit = 7'b1111111 (blank).
- States:
  - IDLE: on an edge with start=1, capture value into the shift register, clear the BCD register and sticky overflow, go to SHIFT with counter=0.
  - SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd,bin} left by 1 and increment the counter. After WIDTH shifts, go to LOAD.
  - LOAD: register the hex outputs and overflow, pulse done, return to IDLE.
- Latency: start accepted at edge k -> busy=1 after edge k; WIDTH shifts occupy edges k+1..k+WIDTH; hex/overflow update and done=1 after edge k+WIDTH+1; busy=0 in that same cycle.
- busy = 1 in SHIFT and LOAD only, 0 in IDLE. done = 1 for exactly one cycle, coinciding with busy falling.
- start while busy=1 is ignored, with no queueing. start in the done cycle is accepted, since the block is in IDLE.
- Overflow: sticky, set if a 1 is shifted out of the MSB of the top BCD digit during any shift. When overflow=1, all digits show dash 7'b0111111 and digit values are discarded.
- Digit encoding (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- hex outputs are registered, stable between conversions, and change only at the LOAD edge.
- Reset mid-conversion aborts the conversion immediately: no done pulse; outputs return to reset values.
- value may change freely after the accepting edge without affecting the result.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: any zero digit above the most significant nonzero digit is blanked (7'b1111111). Digit 0 always shows, so value 0 displays "0". Dashes on overflow are unaffected.
- Undefined: all DIGITS digits are shown, including leading zeros.

Test Plan:
1. WIDTH=6, DIGITS=2: reset=0 mid-run, then release -> hex=14'h3FFF, busy=0, done=0, overflow=0.
2. value=31, start 1 cycle -> busy high 7 cycles, done pulse at edge k+7; hex[13:7]=0110000 (3), hex[6:0]=1111001 (1), overflow=0.
3. value=10 -> hex[13:7]=1111001, hex[6:0]=1000000. Then value=1: with LEADING_ZERO_BLANK_EN, hex[13:7]=1111111; without it, hex[13:7]=1000000.
4. value=0 -> hex[6:0]=1000000 (both builds). Then value=63 -> 6/3 = 0000010/0110000.
5. DIGITS=1, WIDTH=6: value=15 -> overflow=1, hex=0111111. Then value=9 -> overflow=0, hex=0010000.
6. value=21 with start held high through the conversion and a second value=5 presented mid-run -> only 21 is displayed. Next start in the done cycle is accepted and shows 5 after a further 7 cycles. Assert reset mid-conversion -> no done pulse, hex blank.
